if_stage: RTL and testbench

//  Instruction-fetch stage of the MIPS CPU. Owns the PC register and drives the instruction memory address.

---
 rtl/cpu_defs.sv | 23 ++
 rtl/pc_next_sel.sv | 70 +++++++
 rtl/if_stage.sv | 84 ++++++++
 tb/tb_if_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS pipeline.
// Constants and the IF/ID bundle are used by every stage.
package cpu_defs;

    localparam logic [31:0] NOP_INSTR      = 32'h0;
    localparam logic [31:0] RESET_VECTOR   = 32'h0;
    localparam logic [31:0] ALIGN_MASK     = 32'h3;
    localparam int          WORD_BYTES     = 4;
    localparam int          IMEM_WORDS_DEF = 128;

    typedef enum logic [1:0] {
        IFA_HOLD,
        IFA_LOAD,
        IFA_BUBBLE
    } if_act_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage.
// Picks redirect, hold or sequential PC and the IF/ID action.
module pc_next_sel
    import cpu_defs::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_next,
    output logic [31:0] pc4,
    output if_act_e     act,
    output logic        misalign,
    output logic        oor
);

    localparam logic [32:0] LIMIT =
        33'(IMEM_WORDS) * 33'(WORD_BYTES);

    logic in_range;
    logic sel_br;
    logic sel_jp;
    logic sel_st;
    logic sel_nm;

    assign pc4      = pc + 32'(WORD_BYTES);
    assign in_range = {1'b0, pc} < LIMIT;

    // Branch is the older instruction, so it beats a same-cycle jump.
    assign sel_br = branch_taken;
    assign sel_jp = jump & ~branch_taken;
    assign sel_st = stall & ~branch_taken & ~jump;
    assign sel_nm = ~(stall | branch_taken | jump);

    always_comb begin
        pc_next  = pc;
        act      = IFA_HOLD;
        misalign = 1'b0;
        oor      = 1'b0;
        unique case (1'b1)
            sel_br: begin
                pc_next  = branch_target & ~ALIGN_MASK;
                act      = IFA_BUBBLE;
                misalign = |branch_target[1:0];
            end
            sel_jp: begin
                pc_next  = jump_target & ~ALIGN_MASK;
                act      = IFA_BUBBLE;
                misalign = |jump_target[1:0];
            end
            sel_st: begin
                pc_next = pc;
                act     = IFA_HOLD;
            end
            sel_nm: begin
                pc_next = pc4;
                act     = in_range ? IFA_LOAD : IFA_BUBBLE;
                oor     = ~in_range;
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register and IF/ID pipeline register.
// Also keeps a sticky fetch fault and a count of valid fetches.
module if_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc4;
    if_act_e     act;
    logic        misalign;
    logic        oor;
    if_id_t      if_id_q;
    logic        fault_q;
    logic [31:0] count_q;

    pc_next_sel #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_sel (
        .pc           (pc_q),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_next      (pc_next),
        .pc4          (pc4),
        .act          (act),
        .misalign     (misalign),
        .oor          (oor)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            if_id_q <= '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
            fault_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_next;
            fault_q <= fault_q | misalign | oor;
            unique case (act)
                IFA_LOAD: begin
                    if_id_q <= '{pc4: pc4, instr: imem_instr, valid: 1'b1};
                    count_q <= count_q + 32'd1;
                end
                IFA_BUBBLE: begin
                    if_id_q <= '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
                end
                default: begin
                    if_id_q <= if_id_q;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random
// redirect/stall traffic compared against a behavioural fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [128];

    int errs   = 0;
    int checks = 0;

    longint unsigned m_pc;
    longint unsigned m_pc4;
    longint unsigned m_instr;
    bit              m_valid;
    bit              m_fault;
    longint unsigned m_count;

    if_stage #(
        .RESET_PC  (32'h0),
        .IMEM_WORDS(128)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .pc           (pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .fetch_fault  (fetch_fault),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[8:2]];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    pc,          32'(m_pc));
        chk({tag, ".pc4"},   if_id_pc4,   32'(m_pc4));
        chk({tag, ".instr"}, if_id_instr, 32'(m_instr));
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
        chk({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
        chk({tag, ".count"}, fetch_count, 32'(m_count));
    endtask

    task automatic model_bubble();
        m_pc4   = 0;
        m_instr = 0;
        m_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = 0;
        model_bubble();
        m_fault = 0;
        m_count = 0;
    endtask

    // One clock with the given controls; model follows the fetch rules.
    task automatic step(input bit s, input bit b, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt);
        longint unsigned tgt;
        stall = s;
        branch_taken = b;
        branch_target = bt;
        jump = j;
        jump_target = jt;
        if (b || j) begin
            tgt = b ? bt : jt;
            if (tgt % 4 != 0) m_fault = 1;
            m_pc = tgt - (tgt % 4);
            model_bubble();
        end else if (!s) begin
            if (m_pc < 128 * 4) begin
                m_instr = mem[m_pc / 4];
                m_pc4   = (m_pc + 4) % (64'd1 << 32);
                m_valid = 1;
                m_count = (m_count + 1) % (64'd1 << 32);
            end else begin
                model_bubble();
                m_fault = 1;
            end
            m_pc = (m_pc + 4) % (64'd1 << 32);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    logic [31:0] save_instr;
    logic [31:0] save_pc4;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0007;
        rst = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        jump = 1'b0;
        jump_target = 32'h0;

        do_reset();
        chk_model("reset");
        chk("reset.pc_lit", pc, 32'h0);

        // First fetch
        step(0, 0, 0, 0, 0);
        chk_model("fetch1");
        chk("fetch1.instr_lit", if_id_instr, 32'h2008_0007);
        chk("fetch1.pc_lit", pc, 32'h4);
        chk("fetch1.count_lit", fetch_count, 32'd1);

        // Stall holds everything
        run(2);
        chk("pre_stall.pc", pc, 32'h0C);
        save_instr = if_id_instr;
        save_pc4 = if_id_pc4;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk_model("stall");
        chk("stall.pc_lit", pc, 32'h0C);
        chk("stall.instr_hold", if_id_instr, save_instr);
        chk("stall.pc4_hold", if_id_pc4, save_pc4);
        chk("stall.count_lit", fetch_count, 32'd3);
        step(0, 0, 0, 0, 0);
        chk_model("resume");
        chk("resume.pc_lit", pc, 32'h10);
        chk("resume.pc4_lit", if_id_pc4, 32'h10);

        // Branch beats jump and stall
        step(1, 1, 32'h4C, 1, 32'h50);
        chk_model("br_prio");
        chk("br_prio.pc_lit", pc, 32'h4C);
        chk("br_prio.valid_lit", 32'(if_id_valid), 32'd0);
        chk("br_prio.count_lit", fetch_count, 32'd4);

        // Misaligned jump sets sticky fault
        step(0, 0, 0, 1, 32'h52);
        chk_model("jmp_mis");
        chk("jmp_mis.pc_lit", pc, 32'h50);
        chk("jmp_mis.fault_lit", 32'(fetch_fault), 32'd1);
        run(10);
        chk_model("fault_sticky");
        chk("fault_sticky.lit", 32'(fetch_fault), 32'd1);

        // Last implemented word, then out of range
        do_reset();
        chk_model("reset2");
        step(0, 0, 0, 1, 32'h1FC);
        step(0, 0, 0, 0, 0);
        chk_model("last_word");
        chk("last_word.valid", 32'(if_id_valid), 32'd1);
        chk("last_word.pc4", if_id_pc4, 32'h200);
        chk("last_word.fault", 32'(fetch_fault), 32'd0);
        step(0, 0, 0, 0, 0);
        chk_model("oor");
        chk("oor.valid", 32'(if_id_valid), 32'd0);
        chk("oor.fault", 32'(fetch_fault), 32'd1);
        chk("oor.pc", pc, 32'h204);

        // PC wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0);
        chk_model("wrap");
        chk("wrap.pc", pc, 32'h0);
        step(0, 0, 0, 0, 0);
        chk_model("wrap_fetch");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit s, b, j;
            logic [31:0] bt, jt;
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
                chk_model("rnd_reset");
            end
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 9) == 0);
            bt = 32'($urandom_range(0, 600));
            jt = 32'($urandom_range(0, 600));
            step(s, b, bt, j, jt);
            chk_model("rnd");
        end

        // Reset mid-stream
        do_reset();
        step(0, 0, 0, 1, 32'h28);
        run(2);
        chk("mid.pc", pc, 32'h30);
        chk("mid.valid", 32'(if_id_valid), 32'd1);
        do_reset();
        chk_model("mid_reset");
        chk("mid_reset.pc", pc, 32'h0);
        chk("mid_reset.count", fetch_count, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
